// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared constants, op encodings and FSM states for the RV32M
//               sequential multiply unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

    localparam int XLEN = 32;

    // funct3[1:0] encodings of the multiply ops
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// ============================================================================
// Module      : mul_step
// Description : One radix-2 shift-add iteration. Conditionally adds the
//               multiplicand into the upper accumulator half (33-bit sum with
//               carry kept), then shifts {carry, acc} and the multiplier right.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_step #(
    parameter int XLEN = mul_pkg::XLEN
) (
    input  logic [2*XLEN-1:0] i_acc,
    input  logic [XLEN-1:0]   i_mcand,
    input  logic [XLEN-1:0]   i_mplier,
    output logic [2*XLEN-1:0] o_acc,
    output logic [XLEN-1:0]   o_mplier
);

    logic [XLEN:0] w_addend;
    logic [XLEN:0] w_sum;

    // Partial-product add on the upper half, then a one-bit right shift of the
    // whole {carry, acc} chain; the multiplier shifts in lockstep.
    always_comb begin
        w_addend = i_mplier[0] ? {1'b0, i_mcand} : '0;
        w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + w_addend;
        o_acc    = {w_sum, i_acc[XLEN-1:1]};
        o_mplier = {1'b0, i_mplier[XLEN-1:1]};
    end

endmodule : mul_step
`default_nettype wire

// File: rtl/seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul
// Description : Multi-cycle RV32M multiply unit (MUL/MULH/MULHSU/MULHU).
//               Operands are converted to sign + magnitude at acceptance,
//               multiplied unsigned over 32 shift-add cycles, sign-fixed in
//               one cycle and returned over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_mul #(
    parameter int XLEN = mul_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    import mul_pkg::*;

    localparam int                  c_cnt_w    = $clog2(XLEN);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(XLEN - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [XLEN-1:0]     c_one_x    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0]   c_one_2x   = {{(2*XLEN-1){1'b0}}, 1'b1};

    state_t              r_state;
    state_t              w_state_nxt;

    logic [1:0]          r_op;
    logic                r_sa;
    logic                r_sb;
    logic [XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]     r_mplier;
    logic [2*XLEN-1:0]   r_acc;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [XLEN-1:0]     r_result;

    logic                w_accept;
    logic                w_sa;
    logic                w_sb;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [2*XLEN-1:0]   w_acc_step;
    logic [XLEN-1:0]     w_mplier_step;
    logic [2*XLEN-1:0]   w_prod;

    // Sign flags and magnitudes of the incoming operands; 0x80000000 negates
    // to itself, which reads as 2^31 when treated as unsigned.
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        case (op)
            OP_MUL:    begin w_sa = 1'b0;        w_sb = 1'b0;        end
            OP_MULH:   begin w_sa = a[XLEN-1];   w_sb = b[XLEN-1];   end
            OP_MULHSU: begin w_sa = a[XLEN-1];   w_sb = 1'b0;        end
            OP_MULHU:  begin w_sa = 1'b0;        w_sb = 1'b0;        end
            default:   begin w_sa = 1'b0;        w_sb = 1'b0;        end
        endcase
        w_mag_a = w_sa ? (~a + c_one_x) : a;
        w_mag_b = w_sb ? (~b + c_one_x) : b;
    end

    mul_step #(
        .XLEN (XLEN)
    ) u_step (
        .i_acc    (r_acc),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier),
        .o_acc    (w_acc_step),
        .o_mplier (w_mplier_step)
    );

    // Sign fix-up of the unsigned magnitude product
    always_comb begin
        w_prod = (r_sa ^ r_sb) ? (~r_acc + c_one_2x) : r_acc;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs; flush overrides every state
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    w_accept    = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                busy        = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (flush) begin
            w_state_nxt = IDLE;
        end
    end

    // Operand capture, shift-add iterations and result update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= OP_MUL;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (!flush) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= op;
                        r_sa     <= w_sa;
                        r_sb     <= w_sb;
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                CALC: begin
                    r_acc    <= w_acc_step;
                    r_mplier <= w_mplier_step;
                    r_cnt    <= r_cnt + c_cnt_one;
                end
                FIX: begin
                    r_result <= (r_op == OP_MUL) ? w_prod[XLEN-1:0]
                                                 : w_prod[2*XLEN-1:XLEN];
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;

endmodule : seq_mul
`default_nettype wire

// File: tb/tb_seq_mul.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_mul
// Description : Self-checking bench for seq_mul: directed corner cases plus
//               randomized ops against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_mul;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    int n_vec;
    int n_err;

    seq_mul #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time guard
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: extend each operand per its signedness, multiply mod 2^64
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        ex = (o == 2'b01 || o == 2'b10) ? {{32{x[31]}}, x} : {32'b0, x};
        ey = (o == 2'b01) ? {{32{y[31]}}, y} : {32'b0, y};
        p  = ex * ey;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; that edge is the accept edge
    task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
    endtask

    // Wait for out_valid, check latency and value, optionally complete handshake
    task automatic finish_op(input string tag, input logic [31:0] exp, input bit take);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd33);
        chk({tag, "_res"}, 64'(result), 64'(exp));
        if (take) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk({tag, "_rdy"}, 64'({in_ready, out_valid}), 64'b10);
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start(o, x, y);
        finish_op(tag, ref_mul(o, x, y), 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] x, y;
        logic [1:0]  o;
        bit          seen;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_out", 64'({in_ready, out_valid, busy}), 64'b100);
        chk("reset_res", 64'(result), 64'd0);

        // Basic and spec-quoted corner products (explicit expected values)
        start(2'b00, 32'd7, 32'd6);
        chk("calc_busy", 64'({in_ready, busy}), 64'b01);
        finish_op("mul_7x6", 32'h0000002A, 1'b1);
        start(2'b01, 32'h80000000, 32'h80000000); finish_op("mulh_min", 32'h40000000, 1'b1);
        start(2'b01, 32'hFFFFFFFF, 32'h00000002); finish_op("mulh_m1x2", 32'hFFFFFFFF, 1'b1);
        start(2'b00, 32'hFFFFFFFF, 32'h00000002); finish_op("mul_m1x2", 32'hFFFFFFFE, 1'b1);
        start(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF); finish_op("mulhsu_ff", 32'hFFFFFFFF, 1'b1);
        start(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF); finish_op("mulhu_ff", 32'hFFFFFFFE, 1'b1);
        start(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF); finish_op("mul_ff", 32'h00000001, 1'b1);

        // Backpressure: result held, new request ignored while DONE
        start(2'b01, 32'h12345678, 32'h9ABCDEF0);
        finish_op("bp", ref_mul(2'b01, 32'h12345678, 32'h9ABCDEF0), 1'b0);
        held = result;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin op = 2'b00; a = 32'd3; b = 32'd5; in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            chk("bp_hold", 64'({out_valid, in_ready, result}), {30'd0, 1'b1, 1'b0, held});
        end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("bp_release", 64'({in_ready, out_valid}), 64'b10);
        start(2'b00, 32'd3, 32'd5); finish_op("bp_3x5", 32'h0000000F, 1'b1);

        // Flush on the 10th CALC cycle
        start(2'b11, 32'hDEADBEEF, 32'hCAFEF00D);
        for (int i = 0; i < 9; i++) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        chk("flush_idle", 64'({in_ready, out_valid, busy}), 64'b100);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_noval", 64'(seen), 64'd0);
        op = 2'b00; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_win", 64'({in_ready, busy}), 64'b10);
        run("post_flush", 2'b01, 32'h7FFFFFFF, 32'h80000000);

        // Reset mid-CALC
        start(2'b11, 32'hFFFFFFFF, 32'h12345678);
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst_mid_out", 64'({in_ready, out_valid, busy}), 64'b100);
        chk("rst_mid_res", 64'(result), 64'd0);
        start(2'b00, 32'h00010000, 32'h00010000); finish_op("rst_mul", 32'h00000000, 1'b1);
        start(2'b11, 32'h00010000, 32'h00010000); finish_op("rst_mulhu", 32'h00000001, 1'b1);

        // Randomized ops with boundary operands mixed in
        for (int i = 0; i < 48; i++) begin
            o = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: x = 32'h80000000;
                1: x = 32'hFFFFFFFF;
                2: x = 32'h0;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: y = 32'h80000000;
                1: y = 32'hFFFFFFFF;
                2: y = 32'h1;
                default: y = $urandom;
            endcase
            run("rand", o, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_mul
`default_nettype wire
